// File: rtl/seq_stream_ctrl_if.sv
// rtl/seq_stream_ctrl_if.sv - word stream, control and detection signals of seq_stream_ctrl
`timescale 1ns/1ps

interface seq_stream_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             flush;
   logic             clear;
   logic             bit_out;
   logic             bit_valid;
   logic             match_pulse;
   logic [CNT_W-1:0] match_count;
   logic             word_done;
   logic             busy;

   modport master (
      output in_valid, in_data, flush, clear,
      input  in_ready, bit_out, bit_valid, match_pulse, match_count, word_done, busy
   );

   modport slave (
      input  in_valid, in_data, flush, clear,
      output in_ready, bit_out, bit_valid, match_pulse, match_count, word_done, busy
   );
endinterface

// File: rtl/seq_stream_ctrl.sv
// rtl/seq_stream_ctrl.sv - serializes words MSB-first into an overlapping "1011" Moore detector
`timescale 1ns/1ps

module seq_stream_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic         clock,
   input  logic         reset,
   seq_stream_ctrl_if.slave s
);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } ctrl_state_t;

   typedef enum logic [2:0] {
      D_ZERO          = 3'd0,
      D_ONE           = 3'd1,
      D_ONEZERO       = 3'd2,
      D_ONEZEROONE    = 3'd3,
      D_ONEZEROONEONE = 3'd4
   } det_state_t;

   ctrl_state_t      state;
   det_state_t       det_state;
   det_state_t       det_next;
   logic [WIDTH-1:0] shreg;
   logic [IDX_W-1:0] bit_idx;
   logic             in_ready_r;
   logic             bit_valid_r;
   logic             match_pulse_r;
   logic             word_done_r;
   logic             busy_r;
   logic [CNT_W-1:0] count_r;
   logic             hit;

   // Serial bit is always the MSB of the shift register; it drains to zero after a word.
   assign s.bit_out     = shreg[WIDTH-1];
   assign s.in_ready    = in_ready_r;
   assign s.bit_valid   = bit_valid_r;
   assign s.match_pulse = match_pulse_r;
   assign s.match_count = count_r;
   assign s.word_done   = word_done_r;
   assign s.busy        = busy_r;

   always_comb begin
      det_next = D_ZERO;
      case (det_state)
         D_ZERO:          det_next = shreg[WIDTH-1] ? D_ONE           : D_ZERO;
         D_ONE:           det_next = shreg[WIDTH-1] ? D_ONE           : D_ONEZERO;
         D_ONEZERO:       det_next = shreg[WIDTH-1] ? D_ONEZEROONE    : D_ZERO;
         D_ONEZEROONE:    det_next = shreg[WIDTH-1] ? D_ONEZEROONEONE : D_ONEZERO;
         D_ONEZEROONEONE: det_next = shreg[WIDTH-1] ? D_ONE           : D_ONEZERO;
         default:         det_next = D_ZERO;
      endcase
   end

   // A detection is an entry into the final state on a consumed bit, never a dwell.
   assign hit = bit_valid_r && (det_next == D_ONEZEROONEONE);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state         <= S_IDLE;
         det_state     <= D_ZERO;
         shreg         <= '0;
         bit_idx       <= '0;
         in_ready_r    <= 1'b1;
         bit_valid_r   <= 1'b0;
         match_pulse_r <= 1'b0;
         word_done_r   <= 1'b0;
         busy_r        <= 1'b0;
         count_r       <= '0;
      end else begin
         match_pulse_r <= hit;

         if (bit_valid_r) begin
            det_state <= det_next;
         end else if (state == S_IDLE && s.flush) begin
            det_state <= D_ZERO;
         end

         if (s.clear) begin
            count_r <= '0;
         end else if (hit && count_r != CNT_MAX) begin
            count_r <= count_r + CNT_W'(1);
         end

         case (state)
            S_IDLE: begin
               if (s.in_valid) begin
                  shreg       <= s.in_data;
                  bit_idx     <= '0;
                  bit_valid_r <= 1'b1;
                  in_ready_r  <= 1'b0;
                  busy_r      <= 1'b1;
                  state       <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               shreg   <= {shreg[WIDTH-2:0], 1'b0};
               bit_idx <= bit_idx + IDX_W'(1);
               if (bit_idx == LAST_IDX) begin
                  bit_valid_r <= 1'b0;
                  word_done_r <= 1'b1;
                  state       <= S_DONE;
               end
            end
            S_DONE: begin
               word_done_r <= 1'b0;
               busy_r      <= 1'b0;
               in_ready_r  <= 1'b1;
               state       <= S_IDLE;
            end
            default: begin
               bit_valid_r <= 1'b0;
               word_done_r <= 1'b0;
               busy_r      <= 1'b0;
               in_ready_r  <= 1'b1;
               state       <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_seq_stream_ctrl.sv
// tb/tb_seq_stream_ctrl.sv - directed scoreboard bench for seq_stream_ctrl
`timescale 1ns/1ps

module tb_seq_stream_ctrl;
   localparam int W = 8;

   typedef struct {
      logic       bv;
      logic       bo;
      logic       mp;
      logic       wd;
      logic       rdy;
      logic       bsy;
      logic [7:0] c8;
      logic [1:0] c2;
   } rec_t;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       flush = 1'b0;
   logic       clear = 1'b0;

   int   total = 0;
   int   bad = 0;
   rec_t exp_q[$];
   logic [3:0] hist = 4'b0000;
   int   m8 = 0;
   int   m2 = 0;

   seq_stream_ctrl_if #(.WIDTH(W), .CNT_W(8)) bus8 ();
   seq_stream_ctrl_if #(.WIDTH(W), .CNT_W(2)) bus2 ();

   assign bus8.in_valid = in_valid;
   assign bus8.in_data  = in_data;
   assign bus8.flush    = flush;
   assign bus8.clear    = clear;
   assign bus2.in_valid = in_valid;
   assign bus2.in_data  = in_data;
   assign bus2.flush    = flush;
   assign bus2.clear    = clear;

   seq_stream_ctrl #(.WIDTH(W), .CNT_W(8)) dut8 (.clock(clock), .reset(reset), .s(bus8));
   seq_stream_ctrl #(.WIDTH(W), .CNT_W(2)) dut2 (.clock(clock), .reset(reset), .s(bus2));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals();
      chk("rst_ready8", bus8.in_ready, 1);
      chk("rst_bv8",    bus8.bit_valid, 0);
      chk("rst_bo8",    bus8.bit_out, 0);
      chk("rst_mp8",    bus8.match_pulse, 0);
      chk("rst_cnt8",   bus8.match_count, 0);
      chk("rst_wd8",    bus8.word_done, 0);
      chk("rst_busy8",  bus8.busy, 0);
      chk("rst_ready2", bus2.in_ready, 1);
      chk("rst_cnt2",   bus2.match_count, 0);
      chk("rst_busy2",  bus2.busy, 0);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (bus8.in_ready !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk("wait_ready", bus8.in_ready, 1);
   endtask

   task automatic idle_flush();
      in_valid = 1'b0;
      wait_ready();
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      hist = 4'b0000;
      chk("flush_ready", bus8.in_ready, 1);
      chk("flush_bv", bus8.bit_valid, 0);
   endtask

   task automatic idle_clear();
      in_valid = 1'b0;
      wait_ready();
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      m8 = 0;
      m2 = 0;
      chk("clear_cnt8", bus8.match_count, 0);
      chk("clear_cnt2", bus2.match_count, 0);
   endtask

   // Sends one word; expected per-cycle outputs come from a 4-bit sliding-window model.
   task automatic xfer(input logic [7:0] d, input bit hold, input bit fl_shift,
                       input int clr_bit, input int rst_bit);
      rec_t r;
      logic pend;
      logic b;
      bit   rst_hit;
      in_data  = d;
      in_valid = 1'b1;
      wait_ready();
      pend = 1'b0;
      for (int k = 0; k < W; k++) begin
         r.bv = 1'b1; r.bo = d[W-1-k]; r.mp = pend; r.wd = 1'b0;
         r.rdy = 1'b0; r.bsy = 1'b1; r.c8 = 8'(m8); r.c2 = 2'(m2);
         exp_q.push_back(r);
         b = d[W-1-k];
         hist = {hist[2:0], b};
         pend = (hist == 4'b1011);
         if (k == clr_bit) begin
            m8 = 0; m2 = 0;
         end else if (pend) begin
            if (m8 < 255) m8++;
            if (m2 < 3) m2++;
         end
      end
      r.bv = 1'b0; r.bo = 1'b0; r.mp = pend; r.wd = 1'b1;
      r.rdy = 1'b0; r.bsy = 1'b1; r.c8 = 8'(m8); r.c2 = 2'(m2);
      exp_q.push_back(r);
      rst_hit = 1'b0;
      @(posedge clock);
      for (int k = 1; k <= W + 1; k++) begin
         @(negedge clock);
         if (rst_hit) begin
            check_reset_vals();
            reset = 1'b1;
            in_valid = 1'b0;
            flush = 1'b0;
            clear = 1'b0;
            exp_q.delete();
            hist = 4'b0000;
            m8 = 0;
            m2 = 0;
            return;
         end
         r = exp_q.pop_front();
         chk($sformatf("bv_%0d", k),    bus8.bit_valid, r.bv);
         chk($sformatf("bo_%0d", k),    bus8.bit_out, r.bo);
         chk($sformatf("mp_%0d", k),    bus8.match_pulse, r.mp);
         chk($sformatf("wd_%0d", k),    bus8.word_done, r.wd);
         chk($sformatf("rdy_%0d", k),   bus8.in_ready, r.rdy);
         chk($sformatf("busy_%0d", k),  bus8.busy, r.bsy);
         chk($sformatf("cnt8_%0d", k),  bus8.match_count, r.c8);
         chk($sformatf("cnt2_%0d", k),  bus2.match_count, r.c2);
         chk($sformatf("mp2_%0d", k),   bus2.match_pulse, r.mp);
         in_valid = hold;
         if (hold) in_data = 8'($urandom);
         flush = fl_shift && (k <= W);
         clear = (k - 1 == clr_bit);
         if (k - 1 == rst_bit) begin
            reset = 1'b0;
            rst_hit = 1'b1;
         end
      end
      flush = 1'b0;
      clear = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clock);
      check_reset_vals();
      reset = 1'b1;
      @(negedge clock);
      check_reset_vals();

      xfer(8'hB0, 1'b0, 1'b0, -1, -1);
      xfer(8'hBB, 1'b0, 1'b0, -1, -1);

      xfer(8'h01, 1'b0, 1'b0, -1, -1);
      xfer(8'h60, 1'b0, 1'b0, -1, -1);
      xfer(8'h01, 1'b0, 1'b0, -1, -1);
      idle_flush();
      xfer(8'h60, 1'b0, 1'b0, -1, -1);

      xfer(8'h01, 1'b0, 1'b1, -1, -1);
      xfer(8'h60, 1'b0, 1'b0, -1, -1);

      xfer(8'hB0, 1'b1, 1'b0, -1, -1);
      xfer(8'h2D, 1'b1, 1'b0, -1, -1);
      xfer(8'h5A, 1'b0, 1'b0, -1, -1);

      idle_clear();
      for (int i = 0; i < 5; i++) xfer(8'hB0, 1'b0, 1'b0, -1, -1);
      chk("sat_cnt2", bus2.match_count, 3);
      xfer(8'hB0, 1'b0, 1'b0, 3, -1);
      chk("clr_cnt2", bus2.match_count, 0);

      xfer(8'hB0, 1'b0, 1'b0, -1, 3);
      xfer(8'h0B, 1'b0, 1'b0, -1, -1);
      chk("post_rst_cnt8", bus8.match_count, 1);

      chk("q_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
